// File: rtl/mips_pkg.sv
// Shared fetch-stage constants and FSM encoding.
// Width defaults match the program_counter BUS_WIDTH used in this core.
package mips_pkg;

  localparam int ADDR_WIDTH  = 9;
  localparam int INSTR_WIDTH = 32;
  localparam int RESET_PC    = 0;

  typedef enum logic [1:0] {
    FETCH_RUN    = 2'd0,
    FETCH_DRAIN  = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry in-order queue: head is the output register, tail is the skid slot.
// Latency: a push shows on the output the next cycle when the queue is empty.
// Backpressure: holds up to two entries; the caller never pushes into a full queue.
module fetch_skid_buffer #(
  parameter int DATA_WIDTH = 41
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= push_dat;
          else             tail <= push_dat;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (occ == 2'd2) begin
            head <= tail;
            tail <= push_dat;
          end else begin
            head <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_vld = (occ != 2'd0);
  assign out_dat = head;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch around an external PC register: issue, redirect/squash, halt.
// Latency: issue at t, memory word at t+1, instr_valid at t+2.
// Backpressure: issue stalls unless the queue can take every outstanding word.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = mips_pkg::ADDR_WIDTH,
  parameter int                    INSTR_WIDTH = mips_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(mips_pkg::RESET_PC)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  pc_q,
  output logic [ADDR_WIDTH-1:0]  pc_next,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  input  logic                   halt,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  localparam int ENTRY_W = INSTR_WIDTH + ADDR_WIDTH;

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic                  req_inflight;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [1:0]            occ;
  logic [2:0]            slots_needed;
  logic                  pop;
  logic                  issue;
  logic                  redirect_take;
  logic                  push;
  logic [ENTRY_W-1:0]    out_dat;

  assign imem_addr = pc_q;
  assign pop       = instr_valid & instr_ready;

  // Slots the queue must have once the in-flight word and a new request both land.
  assign slots_needed  = 3'(occ) + 3'(req_inflight) + 3'd1 - 3'(pop);
  assign issue         = (state == FETCH_RUN) & !redirect_valid & !halt & (slots_needed <= 3'd2);
  assign redirect_take = (state == FETCH_RUN) & redirect_valid & !halt;
  assign push          = req_inflight & !redirect_take;

  always_comb begin
    pc_next = pc_q;
    if (rst)                pc_next = RESET_PC;
    else if (redirect_take) pc_next = redirect_target;
    else if (issue)         pc_next = pc_q + ADDR_WIDTH'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_RUN:    if (halt) state_nxt = req_inflight ? FETCH_DRAIN : FETCH_HALTED;
      FETCH_DRAIN:  if (!req_inflight) state_nxt = FETCH_HALTED;
      FETCH_HALTED: state_nxt = FETCH_HALTED;
      default:      state_nxt = FETCH_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_RUN;
    else     state <= state_nxt;
  end

  // A read lives exactly one cycle, so the flag simply follows issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_inflight <= 1'b0;
      req_pc       <= '0;
    end else begin
      req_inflight <= issue;
      if (issue) req_pc <= pc_q;
    end
  end

  fetch_skid_buffer #(
    .DATA_WIDTH(ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_take),
    .push    (push),
    .push_dat({imem_rdata, req_pc}),
    .pop     (pop),
    .out_vld (instr_valid),
    .out_dat (out_dat),
    .occ     (occ)
  );

  assign {instr, instr_pc} = out_dat;

endmodule
